// File: rtl/pps_cnt_mm.sv
// pps_cnt_mm: measures 1PPS periods in clk cycles, exposed on an 8-bit Avalon-MM slave.
// Define PPS_CNT_ERR_EN to add the signed ERR register (CAPT - TARGET) at 0x0C-0x0F.
module pps_cnt_mm #(
    parameter int unsigned CLK_NOMINAL = 30720000,
    parameter int unsigned TIMEOUT_CYC = 61440000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       pps_in,
    input  logic [7:0] avs_address,
    input  logic       avs_read,
    input  logic       avs_write,
    input  logic [7:0] avs_writedata,
    output logic       avs_waitrequest,
    output logic [7:0] avs_readdata,
    output logic       avs_readdatavalid,
    output logic       irq
);
    localparam logic [31:0] RunMax = 32'hFFFF_FFFF;
    localparam logic [31:0] TmoVal = 32'(TIMEOUT_CYC);
    localparam logic [31:0] NomVal = 32'(CLK_NOMINAL);

    logic [2:0]  r_sync;
    logic [1:0]  r_ctrl;
    logic [2:0]  r_status;  // {tmo, ovf, new}
    logic [31:0] r_run;
    logic [31:0] r_capt;
    logic [31:0] r_target;
    logic [23:0] r_capt_sh;
    logic        r_armed;
    logic        r_rvalid;
    logic        r_irq;
    logic [7:0]  r_rdata;

    logic        w_en;
    logic        w_edge;
    logic        w_capture;
    logic        w_rd;
    logic        w_wr;
    logic        w_sts_wr;
    logic [31:0] w_run_inc;
    logic [7:0]  w_rmux;

    assign w_en      = r_ctrl[0];
    assign w_edge    = r_sync[1] & ~r_sync[2];
    assign w_capture = w_edge & w_en & r_armed;
    assign w_wr      = avs_write;
    assign w_rd      = avs_read & ~avs_write;
    assign w_sts_wr  = w_wr && (avs_address == 8'h01);
    assign w_run_inc = (r_run == RunMax) ? RunMax : r_run + 32'd1;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], pps_in};
        end
    end

    // The first edge after enabling only aligns RUN; later edges capture.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_run   <= '0;
            r_armed <= 1'b0;
            r_capt  <= '0;
        end else if (!w_en) begin
            r_run   <= '0;
            r_armed <= 1'b0;
        end else if (w_edge) begin
            r_run   <= '0;
            r_armed <= 1'b1;
            if (r_armed) begin
                r_capt <= w_run_inc;
            end
        end else begin
            r_run <= w_run_inc;
        end
    end

    // Hardware set wins over a same-cycle software clear.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_status <= '0;
        end else begin
            if (w_capture) begin
                r_status[0] <= 1'b1;
            end else if (w_sts_wr && avs_writedata[0]) begin
                r_status[0] <= 1'b0;
            end
            if (w_en && (r_run == RunMax)) begin
                r_status[1] <= 1'b1;
            end else if (w_sts_wr && avs_writedata[1]) begin
                r_status[1] <= 1'b0;
            end
            if (w_en && (r_run == TmoVal)) begin
                r_status[2] <= 1'b1;
            end else if (w_sts_wr && avs_writedata[2]) begin
                r_status[2] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_ctrl   <= '0;
            r_target <= NomVal;
        end else if (w_wr) begin
            case (avs_address)
                8'h00:   r_ctrl          <= avs_writedata[1:0];
                8'h08:   r_target[7:0]   <= avs_writedata;
                8'h09:   r_target[15:8]  <= avs_writedata;
                8'h0A:   r_target[23:16] <= avs_writedata;
                8'h0B:   r_target[31:24] <= avs_writedata;
                default: ;
            endcase
        end
    end

`ifdef PPS_CNT_ERR_EN
    logic        r_cap_d1;
    logic [31:0] r_err;
    logic [23:0] r_err_sh;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_cap_d1 <= 1'b0;
            r_err    <= '0;
            r_err_sh <= '0;
        end else begin
            r_cap_d1 <= w_capture;
            if (r_cap_d1) begin
                r_err <= r_capt - r_target;
            end
            if (w_rd && (avs_address == 8'h0C)) begin
                r_err_sh <= r_err[31:8];
            end
        end
    end
`endif

    always_comb begin
        w_rmux = 8'h00;
        case (avs_address)
            8'h00:   w_rmux = {6'b0, r_ctrl};
            8'h01:   w_rmux = {5'b0, r_status};
            8'h04:   w_rmux = r_capt[7:0];
            8'h05:   w_rmux = r_capt_sh[7:0];
            8'h06:   w_rmux = r_capt_sh[15:8];
            8'h07:   w_rmux = r_capt_sh[23:16];
            8'h08:   w_rmux = r_target[7:0];
            8'h09:   w_rmux = r_target[15:8];
            8'h0A:   w_rmux = r_target[23:16];
            8'h0B:   w_rmux = r_target[31:24];
`ifdef PPS_CNT_ERR_EN
            8'h0C:   w_rmux = r_err[7:0];
            8'h0D:   w_rmux = r_err_sh[7:0];
            8'h0E:   w_rmux = r_err_sh[15:8];
            8'h0F:   w_rmux = r_err_sh[23:16];
`endif
            default: w_rmux = 8'h00;
        endcase
    end

    // Reading the low byte freezes the upper bytes so a 4-byte read is coherent.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_capt_sh <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_irq    <= r_ctrl[1] & r_status[0];
            if (w_rd) begin
                r_rdata <= w_rmux;
                if (avs_address == 8'h04) begin
                    r_capt_sh <= r_capt[31:8];
                end
            end
        end
    end

    assign avs_waitrequest   = ~reset_reset_n;
    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rvalid;
    assign irq               = r_irq;

endmodule

// File: tb/tb_pps_cnt_mm.sv
// Self-checking bench for pps_cnt_mm: directed steps plus randomized PPS gaps,
// compared against a cycle-timestamp model of the counter and register map.
module tb_pps_cnt_mm;
    localparam int unsigned NOM = 30720000;
    localparam int unsigned TMO = 50;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       pps_in;
    logic [7:0] avs_address;
    logic       avs_read;
    logic       avs_write;
    logic [7:0] avs_writedata;
    logic       avs_waitrequest;
    logic [7:0] avs_readdata;
    logic       avs_readdatavalid;
    logic       irq;

    always #5 clk_clk = ~clk_clk;

    pps_cnt_mm #(
        .CLK_NOMINAL(NOM),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .pps_in           (pps_in),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_waitrequest  (avs_waitrequest),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .irq              (irq)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pps_hold = 0;

    // Model: times are posedge indices; RUN restarts at m_last.
    bit          m_en, m_irq_en, m_armed, m_new, m_tmo, m_pend;
    int          m_last, m_due, m_edge;
    logic [31:0] m_capt, m_err, m_target;
    logic [23:0] m_sh, m_esh;

    task automatic model_reset();
        m_en = 0; m_irq_en = 0; m_armed = 0; m_new = 0; m_tmo = 0; m_pend = 0;
        m_last = 0; m_due = 0; m_edge = -1;
        m_capt = '0; m_err = '0; m_target = NOM; m_sh = '0; m_esh = '0;
    endtask

    function automatic void tmo_upto(input int t);
        if (m_en && m_pend && m_due <= t) begin
            m_tmo  = 1;
            m_pend = 0;
        end
    endfunction

    function automatic void sync_model(input int t);
        if (m_edge >= 0 && m_edge <= t) begin
            tmo_upto(m_edge);
            if (m_en) begin
                if (m_armed) begin
                    m_capt = 32'(m_edge - m_last);
                    m_err  = m_capt - m_target;
                    m_new  = 1;
                end else begin
                    m_armed = 1;
                end
                m_last = m_edge;
                m_due  = m_edge + int'(TMO) + 1;
                m_pend = 1;
            end
            m_edge = -1;
        end
        tmo_upto(t);
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            8'h00: r = {6'b0, m_irq_en, m_en};
            8'h01: r = {5'b0, m_tmo, 1'b0, m_new};
            8'h04: begin r = m_capt[7:0]; m_sh = m_capt[31:8]; end
            8'h05: r = m_sh[7:0];
            8'h06: r = m_sh[15:8];
            8'h07: r = m_sh[23:16];
            8'h08: r = m_target[7:0];
            8'h09: r = m_target[15:8];
            8'h0A: r = m_target[23:16];
            8'h0B: r = m_target[31:24];
`ifdef PPS_CNT_ERR_EN
            8'h0C: begin r = m_err[7:0]; m_esh = m_err[31:8]; end
            8'h0D: r = m_esh[7:0];
            8'h0E: r = m_esh[15:8];
            8'h0F: r = m_esh[23:16];
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
        cyc++;
        if (pps_hold > 0) begin
            pps_hold--;
            if (pps_hold == 0) pps_in = 1'b0;
        end
    endtask

    task automatic pulse();
        sync_model(cyc);
        pps_in   = 1'b1;
        pps_hold = 5;
        m_edge   = cyc + 3;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bit ne;
        sync_model(cyc);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write = 1'b0;
        case (a)
            8'h00: begin
                ne = d[0];
                if (ne && !m_en) begin
                    m_last = cyc; m_due = cyc + int'(TMO) + 1; m_pend = 1; m_armed = 0;
                end
                if (!ne) begin
                    m_pend = 0; m_armed = 0;
                end
                m_en = ne;
                m_irq_en = d[1];
            end
            8'h01: begin
                if (d[0]) m_new = 0;
                if (d[2]) m_tmo = 0;
            end
            8'h08: m_target[7:0]   = d;
            8'h09: m_target[15:8]  = d;
            8'h0A: m_target[23:16] = d;
            8'h0B: m_target[31:24] = d;
            default: ;
        endcase
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, output logic [7:0] d);
        logic [7:0] e;
        sync_model(cyc);
        e = model_rd(a);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read = 1'b0;
        chk({tag, "_valid"}, avs_readdatavalid, 1);
        d = avs_readdata;
        chk(tag, d, e);
    endtask

    task automatic rd32(input string tag, input logic [7:0] base, output logic [31:0] v);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            rd_chk(tag, base + 8'(i), b);
            v[8*i +: 8] = b;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    logic [7:0]  d8;
    logic [31:0] v32;
    logic [7:0]  exp_b [4];
    int          g, e_cyc;

    initial begin
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        pps_in = 0; reset_reset_n = 0;
        model_reset();

        // Reset state
        repeat (4) tick();
        chk("rst_waitreq", avs_waitrequest, 1);
        chk("rst_irq", irq, 0);
        chk("rst_rvalid", avs_readdatavalid, 0);
        chk("rst_rdata", avs_readdata, 0);
        reset_reset_n = 1;
        tick();
        chk("idle_waitreq", avs_waitrequest, 0);
        rd_chk("tgt0", 8'h08, d8); chk("tgt0_const", d8, 8'h00);
        rd_chk("tgt1", 8'h09, d8); chk("tgt1_const", d8, 8'hC0);
        rd_chk("tgt2", 8'h0A, d8); chk("tgt2_const", d8, 8'hD4);
        rd_chk("tgt3", 8'h0B, d8); chk("tgt3_const", d8, 8'h01);
        rd_chk("ctrl_rst", 8'h00, d8);
        rd_chk("sts_rst", 8'h01, d8);
        rd32("capt_rst", 8'h04, v32);

        // Unmapped access and back-to-back reads
        bus_write(8'h30, 8'hFF);
        bus_write(8'h02, 8'hFF);
        rd_chk("unmapped", 8'h20, d8); chk("unmapped_const", d8, 8'h00);
        rd_chk("ctrl_after_unmapped", 8'h00, d8);
        sync_model(cyc);
        for (int i = 0; i < 4; i++) exp_b[i] = model_rd(8'h08 + 8'(i));
        avs_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            avs_address = 8'h08 + 8'(i);
            tick();
            chk("b2b_valid", avs_readdatavalid, 1);
            chk("b2b_data", avs_readdata, {24'h0, exp_b[i]});
        end
        avs_read = 1'b0;
        tick();
        chk("b2b_idle", avs_readdatavalid, 0);

        // Nominal capture: three edges 1000 cycles apart, first one only arms
        bus_write(8'h00, 8'h03);
        pulse(); repeat (1000) tick();
        pulse(); repeat (1000) tick();
        pulse(); repeat (10) tick();
        rd_chk("sts_nom", 8'h01, d8);
        chk("sts_nom_new", d8[0], 1);
        rd32("capt_nom", 8'h04, v32);
        chk("capt_nom_const", v32, 32'd1000);
        chk("irq_nom", irq, 1);
`ifdef PPS_CNT_ERR_EN
        rd32("err_nom", 8'h0C, v32);
        chk("err_nom_const", v32, 32'hFFFF_FFFF - 32'(NOM) + 32'd1001);
`else
        rd32("err_off", 8'h0C, v32);
        chk("err_off_const", v32, 32'h0);
`endif

        // Interrupt clear, then W1C colliding with an edge
        bus_write(8'h01, 8'h01);
        chk("irq_lag", irq, 1);
        tick();
        chk("irq_clr", irq, {31'h0, m_irq_en & m_new});
        chk("irq_clr_const", irq, 0);
        pulse(); tick(); tick();
        bus_write(8'h01, 8'h01);
        repeat (5) tick();
        rd_chk("sts_w1c_edge", 8'h01, d8);
        chk("sts_w1c_edge_new", d8[0], 1);
        chk("irq_w1c_edge", irq, 1);

        // Atomic multi-byte read across a capture
        rd_chk("atom_b0", 8'h04, d8);
        sync_model(cyc);
        do g = $urandom_range(300, 700); while (8'(g >> 8) == m_capt[15:8]);
        wait_until(m_last + g - 3);
        pulse(); repeat (5) tick();
        rd_chk("atom_b1_old", 8'h05, d8);
        chk("atom_b1_not_new", (d8 == 8'(g >> 8)) ? 1 : 0, 0);
        rd32("atom_new", 8'h04, v32);
        chk("atom_new_val", v32, 32'(g));

        // TARGET byte-wise write
        for (int i = 0; i < 4; i++) bus_write(8'h08 + 8'(i), 8'($urandom_range(0, 255)));
        rd32("tgt_rw", 8'h08, v32);
        avs_read = 1'b1;
        bus_write(8'h08, 8'h5A);
        avs_read = 1'b0;
        chk("rw_is_write", avs_readdatavalid, 0);
        rd_chk("rw_tgt0", 8'h08, d8);

        // Randomized periods, some under and some over the timeout
        for (int k = 0; k < 8; k++) begin
            sync_model(cyc);
            g = $urandom_range(25, 300);
            wait_until(m_last + g - 3);
            pulse(); repeat (6) tick();
            rd_chk("rnd_sts", 8'h01, d8);
            rd32("rnd_capt", 8'h04, v32);
            rd32("rnd_err", 8'h0C, v32);
            chk("rnd_irq", irq, {31'h0, m_irq_en & m_new});
            if ($urandom_range(0, 1) == 1) bus_write(8'h01, 8'h05);
        end

        // Disabled: edges leave CAPT alone; then timeout
        bus_write(8'h00, 8'h00);
        bus_write(8'h01, 8'h07);
        sync_model(cyc);
        v32 = m_capt;
        pulse(); repeat (8) tick();
        rd32("capt_dis", 8'h04, v32);
        bus_write(8'h00, 8'h01);
        pulse();
        e_cyc = cyc + 3;
        wait_until(e_cyc + 60);
        rd_chk("sts_tmo", 8'h01, d8); chk("sts_tmo_const", d8, 8'h04);
        pulse(); repeat (6) tick();
        rd_chk("sts_tmo_edge", 8'h01, d8); chk("sts_tmo_edge_const", d8, 8'h05);

        // Reset in the same cycle as a read request drops its valid pulse
        avs_address = 8'h00;
        avs_read = 1'b1;
        reset_reset_n = 0;
        tick();
        chk("rst_rd_valid", avs_readdatavalid, 0);
        chk("rst_rd_waitreq", avs_waitrequest, 1);
        avs_read = 1'b0;
        tick();
        chk("rst_rd_valid2", avs_readdatavalid, 0);
        chk("rst_rd_irq", irq, 0);
        reset_reset_n = 1;
        model_reset();
        tick();
        rd_chk("ctrl_rst2", 8'h00, d8);
        rd_chk("sts_rst2", 8'h01, d8);
        rd32("capt_rst2", 8'h04, v32);
        rd32("tgt_rst2", 8'h08, v32);
        chk("tgt_rst2_const", v32, 32'(NOM));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
